mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single Data_Memory line port (256-bit, ack-based) between two cache controllers: instruction-cache refill (requester I) and dcache_controller (requester D).
- Sits between the cache controllers and Data_Memory in CPU.
- Latches the winning request and holds it stable on the memory port until mem_ack_i.
- Routes ack and read data back to the granted requester only.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
i_enable_i  in  1  requester I request valid
i_write_i  in  1  requester I write (1) / read (0)
i_addr_i  in  ADDR_W  requester I line address
i_data_i  in  LINE_W  requester I write data
i_data_o  out  LINE_W  read data to I
i_ack_o  out  1  request complete to I
d_enable_i  in  1  requester D request valid
d_write_i  in  1  requester D write / read
d_addr_i  in  ADDR_W  requester D line address
d_data_i  in  LINE_W  requester D write data
d_data_o  out  LINE_W  read data to D
d_ack_o  out  1  request complete to D
mem_enable_o  out  1  to Data_Memory enable_i
mem_write_o  out  1  to Data_Memory write_i
mem_addr_o  out  ADDR_W  to Data_Memory addr_i
mem_data_o  out  LINE_W  to Data_Memory data_i
mem_data_i  in  LINE_W  from Data_Memory data_o
mem_ack_i  in  1  from Data_Memory ack_o
busy_o  out  1  transaction in flight

Behaviour:
- Clocking and reset: one clock. rst_i is asynchronous and active-low; the FSM and all registers clear while rst_i=0.
- Reset values: state=IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; busy_o=0; i_ack_o=0, d_ack_o=0; priority pointer=D.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE: sample enables on the clock edge.
  - Only one enable high: grant that requester.
  - Both high: grant per the arbitration policy (see Optional Feature).
  - On grant: register write/addr/data of the winner into the mem_* output registers, set mem_enable_o=1 and busy_o=1, enter GRANT_x.
  - Latency: request high in cycle N gives mem_enable_o=1 from cycle N+1.
- GRANT_x:
  - mem_* outputs are held constant regardless of requester inputs. A requester dropping enable mid-transaction is ignored; the transaction completes.
  - On mem_ack_i=1: x_ack_o=1 combinationally in the same cycle, and x_data_o=mem_data_i.
  - On the next edge: mem_enable_o=0, busy_o=0, return to IDLE.
- Ack routing: the non-granted ack is always 0. mem_ack_i seen in IDLE is ignored (no ack forwarded). x_data_o = mem_data_i whenever granted, else 0.
- Minimum gap: one IDLE cycle between transactions. A requester still holding enable after its ack is treated as a new request.
- Simultaneous events: mem_ack_i in the same cycle a new request arrives means the new request is sampled in the following IDLE cycle.
- Reset mid-transaction: abort immediately, mem_enable_o=0. The pending requester receives no ack and must reissue.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, grant the requester other than the last granted one. The pointer updates on every grant and resets to favour D.
- Undefined: fixed priority, D always wins ties (data misses stall the whole pipeline). No pointer register.

Decomposition:
- Shared package/Define.v additions:
  - state encodings ARB_IDLE=2'd0, ARB_GRANT_I=2'd1, ARB_GRANT_D=2'd2
  - LINE_LEN=256
  - requester ID constants REQ_I=1'b0, REQ_D=1'b1
- One sub-module: mem_arb_pick. Purely combinational winner selection from (i_en, d_en, last_grant); isolates the ifdef'd policy.

Test Plan:
- D-only read: d_enable_i=1, d_addr_i=32'h0000_0400 at cycle 0 -> mem_enable_o=1, mem_addr_o=32'h400 from cycle 1; on mem_ack_i with mem_data_i=256'hA5.. -> d_ack_o=1, d_data_o=256'hA5.. same cycle; i_ack_o stays 0.
- Tie, fixed priority (macro undefined): i and d raised together twice -> D granted both times; I served after each D ack plus one IDLE cycle.
- Tie, round-robin (macro defined): three back-to-back ties -> grant order D, I, D.
- Stability: during GRANT_I, change i_addr_i from 32'h20 to 32'h40 and drop i_enable_i -> mem_addr_o stays 32'h20, mem_enable_o held until ack, i_ack_o pulses once.
- D write: d_write_i=1, d_data_i=256'h1234.. -> mem_write_o=1 and mem_data_o matches from cycle 1; after ack, busy_o=0 the next cycle.
- Reset mid-transaction: assert rst_i=0 during GRANT_D before ack -> all outputs 0 asynchronously; after release, a stray mem_ack_i produces no requester ack.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the Data_Memory port arbiter: FSM encodings,
// line width and requester IDs.
package mem_port_arbiter_pkg;

    localparam int LINE_LEN = 256;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the two requesters.
// Policy selected by MEM_ARB_ROUND_ROBIN_EN (defined: alternate on ties, else D wins ties).
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic i_en,
    input  logic d_en,
    input  logic pref,
    output logic valid,
    output logic winner
);

    assign valid = i_en | d_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the favoured requester (the one not granted last) wins.
    assign winner = (i_en && d_en) ? pref : (d_en ? REQ_D : REQ_I);
`else
    logic unused_pref;
    assign unused_pref = pref;
    assign winner      = d_en ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single 256-bit Data_Memory port between icache refill (I) and
// dcache_controller (D). Optional round-robin ties: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = LINE_LEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_enable_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [LINE_W-1:0] i_data_i,
    output logic [LINE_W-1:0] i_data_o,
    output logic              i_ack_o,
    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic [LINE_W-1:0] d_data_o,
    output logic              d_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o
);

    arb_state_t state_q, state_d;
    logic       grant_valid;
    logic       grant_id;
    logic       pref;
    logic       take;

    assign take = (state_q == ARB_IDLE) && grant_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic pref_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)    pref_q <= REQ_D;
        else if (take) pref_q <= ~grant_id;
    end

    assign pref = pref_q;
`else
    assign pref = REQ_D;
`endif

    mem_arb_pick u_pick (
        .i_en   (i_enable_i),
        .d_en   (d_enable_i),
        .pref   (pref),
        .valid  (grant_valid),
        .winner (grant_id)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:    if (grant_valid) state_d = (grant_id == REQ_D) ? ARB_GRANT_D : ARB_GRANT_I;
            ARB_GRANT_I,
            ARB_GRANT_D: if (mem_ack_i) state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    // The winner's request is captured once and held until ack, so requesters
    // may change or drop their inputs mid-transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
        end else if (take) begin
            mem_write_o <= (grant_id == REQ_D) ? d_write_i : i_write_i;
            mem_addr_o  <= (grant_id == REQ_D) ? d_addr_i  : i_addr_i;
            mem_data_o  <= (grant_id == REQ_D) ? d_data_i  : i_data_i;
        end
    end

    assign mem_enable_o = (state_q != ARB_IDLE);
    assign busy_o       = (state_q != ARB_IDLE);

    assign i_ack_o  = (state_q == ARB_GRANT_I) && mem_ack_i;
    assign d_ack_o  = (state_q == ARB_GRANT_D) && mem_ack_i;
    assign i_data_o = (state_q == ARB_GRANT_I) ? mem_data_i : '0;
    assign d_data_o = (state_q == ARB_GRANT_D) ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-level model (honours MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              i_enable_i, i_write_i, d_enable_i, d_write_i;
    logic [ADDR_W-1:0] i_addr_i, d_addr_i, mem_addr_o;
    logic [LINE_W-1:0] i_data_i, d_data_i, i_data_o, d_data_o, mem_data_o, mem_data_i;
    logic              i_ack_o, d_ack_o, mem_enable_o, mem_write_o, mem_ack_i, busy_o;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: who owns the port and what request it latched.
    int                m_owner;   // 0 none, 1 I, 2 D
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_data;
    logic              m_favour_d;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_enable_i   (i_enable_i),
        .i_write_i    (i_write_i),
        .i_addr_i     (i_addr_i),
        .i_data_i     (i_data_i),
        .i_data_o     (i_data_o),
        .i_ack_o      (i_ack_o),
        .d_enable_i   (d_enable_i),
        .d_write_i    (d_write_i),
        .d_addr_i     (d_addr_i),
        .d_data_i     (d_data_i),
        .d_data_o     (d_data_o),
        .d_ack_o      (d_ack_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .busy_o       (busy_o)
    );

    task automatic model_reset();
        m_owner    = 0;
        m_wr       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_favour_d = 1'b1;
    endtask

    task automatic model_edge();
        logic pick_d;
        logic tie_d;
        if (m_owner == 0) begin
            if (i_enable_i || d_enable_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                tie_d = m_favour_d;
`else
                tie_d = 1'b1;
`endif
                pick_d     = d_enable_i && (!i_enable_i || tie_d);
                m_owner    = pick_d ? 2 : 1;
                m_wr       = pick_d ? d_write_i : i_write_i;
                m_addr     = pick_d ? d_addr_i  : i_addr_i;
                m_data     = pick_d ? d_data_i  : i_data_i;
                m_favour_d = !pick_d;
            end
        end else if (mem_ack_i) begin
            m_owner = 0;
        end
    endtask

    // Called right after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        @(posedge clk_i);
        if (rst_i) model_edge();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        i_enable_i = 0; i_write_i = 0; i_addr_i = '0; i_data_i = '0;
        d_enable_i = 0; d_write_i = 0; d_addr_i = '0; d_data_i = '0;
        mem_data_i = '0; mem_ack_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        clear_inputs();
        model_reset();
        step();
        step();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [3+ADDR_W+LINE_W+2-1:0] obs;
        do_reset();
        #1;
        obs = {mem_enable_o, mem_write_o, busy_o, mem_addr_o, mem_data_o, i_ack_o, d_ack_o};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: en=%b wr=%b busy=%b addr=%h iack=%b dack=%b, required all zero",
                     mem_enable_o, mem_write_o, busy_o, mem_addr_o, i_ack_o, d_ack_o);
        end
    endtask

    task automatic test_d_read();
        logic [LINE_W-1:0] rd;
        rd = {32{8'hA5}};
        do_reset();
        d_enable_i = 1; d_addr_i = 32'h0000_0400;
        #1;
        checks++;
        if (mem_enable_o !== 1'b0) begin
            failures++; $display("FAIL dread_cycle0_en: got %b want 0", mem_enable_o);
        end
        step();
        d_enable_i = 0;
        #1;
        checks++;
        if ({mem_enable_o, busy_o, mem_write_o, mem_addr_o} !== {3'b110, 32'h400}) begin
            failures++;
            $display("FAIL dread_cycle1: en=%b busy=%b wr=%b addr=%h want 1 1 0 00000400",
                     mem_enable_o, busy_o, mem_write_o, mem_addr_o);
        end
        step();
        mem_data_i = rd; mem_ack_i = 1;
        #1;
        checks++;
        if ({d_ack_o, i_ack_o} !== 2'b10 || d_data_o !== rd || i_data_o !== '0) begin
            failures++;
            $display("FAIL dread_ack: dack=%b iack=%b dmatch=%b izero=%b want 1 0 1 1",
                     d_ack_o, i_ack_o, d_data_o === rd, i_data_o === '0);
        end
        step();
        mem_ack_i = 0;
        #1;
        checks++;
        if ({mem_enable_o, busy_o, d_ack_o} !== 3'b000) begin
            failures++;
            $display("FAIL dread_done: en=%b busy=%b dack=%b want 000", mem_enable_o, busy_o, d_ack_o);
        end
    endtask

    task automatic test_stability();
        int pulses;
        do_reset();
        i_enable_i = 1; i_addr_i = 32'h20;
        step();
        i_addr_i = 32'h40; i_enable_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({mem_enable_o, mem_addr_o} !== {1'b1, 32'h20}) begin
                failures++;
                $display("FAIL stable_hold[%0d]: en=%b addr=%h want 1 00000020", k, mem_enable_o, mem_addr_o);
            end
            step();
        end
        mem_ack_i = 1; mem_data_i = {8{32'hCAFE_0001}};
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (i_ack_o === 1'b1) pulses++;
            step();
            mem_ack_i = 0;
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL stable_ack_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_d_write();
        logic [LINE_W-1:0] wd;
        wd = {8{32'h1234_5678}};
        do_reset();
        d_enable_i = 1; d_write_i = 1; d_data_i = wd; d_addr_i = 32'h80;
        step();
        d_enable_i = 0; d_write_i = 0; d_data_i = '0;
        #1;
        checks++;
        if (mem_write_o !== 1'b1 || mem_data_o !== wd || mem_enable_o !== 1'b1) begin
            failures++;
            $display("FAIL dwrite_latch: wr=%b en=%b datamatch=%b want 1 1 1",
                     mem_write_o, mem_enable_o, mem_data_o === wd);
        end
        mem_ack_i = 1;
        step();
        mem_ack_i = 0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++; $display("FAIL dwrite_busy_clear: got %b want 0", busy_o);
        end
    endtask

    task automatic test_tie();
        do_reset();
        i_addr_i = 32'h20; d_addr_i = 32'h400;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        begin
            logic [ADDR_W-1:0] order [3];
            order[0] = 32'h400; order[1] = 32'h20; order[2] = 32'h400;
            i_enable_i = 1; d_enable_i = 1;
            for (int k = 0; k < 3; k++) begin
                step();
                mem_ack_i = 1;
                #1;
                checks++;
                if (mem_addr_o !== order[k]) begin
                    failures++; $display("FAIL rr_tie[%0d]: addr=%h want %h", k, mem_addr_o, order[k]);
                end
                step();
                mem_ack_i = 0;
            end
            i_enable_i = 0; d_enable_i = 0;
        end
`else
        for (int k = 0; k < 2; k++) begin
            i_enable_i = 1; d_enable_i = 1;
            step();
            d_enable_i = 0; mem_ack_i = 1;
            #1;
            checks++;
            if ({mem_addr_o, d_ack_o, i_ack_o} !== {32'h400, 2'b10}) begin
                failures++;
                $display("FAIL tie_fixed_d[%0d]: addr=%h dack=%b iack=%b want 00000400 1 0",
                         k, mem_addr_o, d_ack_o, i_ack_o);
            end
            step();
            mem_ack_i = 0;
            #1;
            checks++;
            if (busy_o !== 1'b0) begin
                failures++; $display("FAIL tie_fixed_gap[%0d]: busy=%b want 0", k, busy_o);
            end
            step();
            #1;
            checks++;
            if ({mem_enable_o, mem_addr_o} !== {1'b1, 32'h20}) begin
                failures++;
                $display("FAIL tie_fixed_i[%0d]: en=%b addr=%h want 1 00000020", k, mem_enable_o, mem_addr_o);
            end
            i_enable_i = 0; mem_ack_i = 1;
            step();
            mem_ack_i = 0;
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_enable_i = 1; d_addr_i = 32'h600;
        step();
        d_enable_i = 0;
        #1;
        rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({mem_enable_o, busy_o, mem_write_o, mem_addr_o, d_ack_o, i_ack_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: en=%b busy=%b addr=%h want 0 0 0", mem_enable_o, busy_o, mem_addr_o);
        end
        step();
        rst_i = 1'b1;
        mem_ack_i = 1; mem_data_i = {8{32'hDEAD_BEEF}};
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({d_ack_o, i_ack_o, mem_enable_o} !== 3'b000 || d_data_o !== '0) begin
                failures++;
                $display("FAIL reset_mid_stray_ack[%0d]: dack=%b iack=%b en=%b want 000",
                         k, d_ack_o, i_ack_o, mem_enable_o);
            end
            step();
        end
        mem_ack_i = 0;
    endtask

    task automatic test_random();
        logic [2+1+ADDR_W+2-1:0] exp_ctl, obs_ctl;
        logic [LINE_W-1:0]        exp_i, exp_d;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            i_enable_i = ($urandom_range(0, 2) != 0);
            d_enable_i = ($urandom_range(0, 2) != 0);
            i_write_i  = $urandom_range(0, 1);
            d_write_i  = $urandom_range(0, 1);
            i_addr_i   = $urandom();
            d_addr_i   = $urandom();
            i_data_i   = {8{$urandom()}};
            d_data_i   = {8{$urandom()}};
            mem_data_i = {8{$urandom()}};
            mem_ack_i  = ($urandom_range(0, 2) == 0);
            #1;
            exp_ctl = {m_owner != 0, m_owner != 0, m_wr, m_addr,
                       m_owner == 1 && mem_ack_i, m_owner == 2 && mem_ack_i};
            obs_ctl = {busy_o, mem_enable_o, mem_write_o, mem_addr_o, i_ack_o, d_ack_o};
            exp_i   = (m_owner == 1) ? mem_data_i : '0;
            exp_d   = (m_owner == 2) ? mem_data_i : '0;
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL rand_ctl[%0d]: got %h want %h", n, obs_ctl, exp_ctl);
            end
            checks++;
            if (mem_data_o !== m_data) begin
                failures++; $display("FAIL rand_memdata[%0d]: got %h want %h", n, mem_data_o, m_data);
            end
            checks++;
            if (i_data_o !== exp_i || d_data_o !== exp_d) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: i_ok=%b d_ok=%b owner=%0d", n,
                         i_data_o === exp_i, d_data_o === exp_d, m_owner);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst_i = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        test_reset();
        test_d_read();
        test_stability();
        test_d_write();
        test_tie();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
